// File: rtl/comp_multiplier_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_multiplier_if                                              |
// | Purpose  : Handshake and operand bundle for the sequential multiplier.     |
// |            The controller (master) drives Run and the operands. The        |
// |            multiplier (slave) returns Product and Ready.                   |
// | Signals  : Run          start request, level-sensitive                     |
// |            Multiplicand operand A, WIDTH bits                              |
// |            Multiplier   operand B, WIDTH bits                              |
// |            Product      2*WIDTH-bit result, valid while Ready=1            |
// |            Ready        result complete                                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface comp_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               Run;
  logic [WIDTH-1:0]   Multiplicand;
  logic [WIDTH-1:0]   Multiplier;
  logic [2*WIDTH-1:0] Product;
  logic               Ready;

  modport master (
    output Run,
    output Multiplicand,
    output Multiplier,
    input  Product,
    input  Ready
  );

  modport slave (
    input  Run,
    input  Multiplicand,
    input  Multiplier,
    output Product,
    output Ready
  );
endinterface
`default_nettype wire

// File: rtl/comp_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_multiplier                                                 |
// | Purpose  : Shift-and-add multiplier, one add/shift step per clock.         |
// |            WIDTH steps per operation; Ready rises WIDTH+1 edges after the  |
// |            edge that samples Run.                                          |
// | Ports    : clk    rising-edge clock                                        |
// |            Reset  asynchronous, active-high reset                          |
// |            bus    comp_multiplier_if.slave (Run, Multiplicand, Multiplier, |
// |                   Product, Ready)                                          |
// | Option   : COMPMUL_SIGNED_EN -- when defined, operands are two's-          |
// |            complement and Booth radix-2 recoding is used. Latency and      |
// |            handshake do not change.                                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module comp_multiplier #(
  parameter int WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         Reset,
  comp_multiplier_if.slave  bus
);

  localparam int unsigned      c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_ITER = c_CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2*WIDTH-1:0]   r_prod,  w_prod_nxt;
  logic [WIDTH-1:0]     r_mcand, w_mcand_nxt;
  logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic                 r_armed, w_armed_nxt;
  logic [WIDTH:0]       w_sum;
`ifdef COMPMUL_SIGNED_EN
  logic                 r_prev, w_prev_nxt;
`endif

  // Upper-half update for one step. The sum is WIDTH+1 bits so the carry
  // (unsigned) or the true sign (Booth) survives into the shift.
  always_comb begin
    w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
`ifdef COMPMUL_SIGNED_EN
    case ({r_prod[0], r_prev})
      2'b10:   w_sum = {r_prod[2*WIDTH-1], r_prod[2*WIDTH-1:WIDTH]}
                       - {r_mcand[WIDTH-1], r_mcand};
      2'b01:   w_sum = {r_prod[2*WIDTH-1], r_prod[2*WIDTH-1:WIDTH]}
                       + {r_mcand[WIDTH-1], r_mcand};
      default: w_sum = {r_prod[2*WIDTH-1], r_prod[2*WIDTH-1:WIDTH]};
    endcase
`else
    if (r_prod[0]) begin
      w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt = r_state;
    w_prod_nxt  = r_prod;
    w_mcand_nxt = r_mcand;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
`ifdef COMPMUL_SIGNED_EN
    w_prev_nxt  = r_prev;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        // From DONE a restart is only honoured after Run has been seen low,
        // so a held Run keeps the finished result on the outputs.
        if (bus.Run && (r_state == S_IDLE || r_armed)) begin
          w_state_nxt = S_CALC;
          w_mcand_nxt = bus.Multiplicand;
          w_prod_nxt  = {{WIDTH{1'b0}}, bus.Multiplier};
          w_cnt_nxt   = '0;
          w_armed_nxt = 1'b0;
`ifdef COMPMUL_SIGNED_EN
          w_prev_nxt  = 1'b0;
`endif
        end else if (r_state == S_DONE && !bus.Run) begin
          w_armed_nxt = 1'b1;
        end
      end
      S_CALC: begin
        // WIDTH shift steps, then one more edge to enter DONE so that Ready
        // appears WIDTH+1 edges after the start edge.
        if (r_cnt == c_ITER) begin
          w_state_nxt = S_DONE;
        end else begin
          w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
          w_cnt_nxt  = r_cnt + c_CNT_W'(1);
`ifdef COMPMUL_SIGNED_EN
          w_prev_nxt = r_prod[0];
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
`ifdef COMPMUL_SIGNED_EN
      r_prev  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_prod  <= w_prod_nxt;
      r_mcand <= w_mcand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
`ifdef COMPMUL_SIGNED_EN
      r_prev  <= w_prev_nxt;
`endif
    end
  end

  assign bus.Product = r_prod;
  assign bus.Ready   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_comp_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_comp_multiplier                                              |
// | Purpose  : Self-checking bench for comp_multiplier: behavioural model of   |
// |            the handshake and the arithmetic, a per-cycle compare process,  |
// |            directed literal cases and randomized operations.               |
// | Option   : COMPMUL_SIGNED_EN selects signed expectations.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_comp_multiplier;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  comp_multiplier_if #(.WIDTH(W)) bus ();

  comp_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPMUL_SIGNED_EN
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    logic [2*W-1:0] ua, ub;
    ua = a;
    ub = b;
    return ua * ub;
`endif
  endfunction

  // Behavioural model: an operation is "in flight" for LAT edges, then the
  // result is shown until Run has gone low and come back high.
  bit             m_active, m_ready, m_armed, m_clear;
  int             m_edges;
  logic [2*W-1:0] m_exp;

  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_active = 1'b0; m_ready = 1'b0; m_armed = 1'b0; m_clear = 1'b1;
      m_edges  = 0;    m_exp   = '0;
    end else if (m_active) begin
      m_edges++;
      if (m_edges == LAT) begin
        m_active = 1'b0; m_ready = 1'b1; m_armed = 1'b0;
      end
    end else if (bus.Run && (!m_ready || m_armed)) begin
      m_active = 1'b1; m_ready = 1'b0; m_clear = 1'b0; m_edges = 0;
      m_exp    = ref_mul(bus.Multiplicand, bus.Multiplier);
    end else if (m_ready && !bus.Run) begin
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.Ready !== m_ready) begin
        errors++;
        $display("FAIL ready_cycle t=%0t got %b want %b", $time, bus.Ready, m_ready);
      end
      if (m_ready || m_clear) begin
        checks++;
        if (bus.Product !== (m_ready ? m_exp : '0)) begin
          errors++;
          $display("FAIL product_cycle t=%0t got %h want %h", $time, bus.Product,
                   m_ready ? m_exp : '0);
        end
      end
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One operation: start, optionally swap operands after the start edge or
  // wiggle Run during CALC, wait (bounded) for Ready and check latency/result.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit lit, input bit swap,
                        input bit jitter);
    int n;
    bit got;
    @(negedge clk);
    bus.Multiplicand = a;
    bus.Multiplier   = b;
    bus.Run          = 1'b1;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    while (!got && n < LAT + 8) begin
      @(negedge clk);
      if (swap && n == 0) begin
        bus.Multiplicand = 32'd7;
        bus.Multiplier   = 32'd7;
      end
      if (jitter) bus.Run = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (bus.Ready) got = 1'b1;
    end
    check({name, "_latency"}, 64'(got ? n : -1), 64'(LAT));
    check({name, "_product"}, bus.Product, exp);
    if (lit) check({name, "_model"}, m_exp, exp);
    @(negedge clk);
    bus.Run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    Reset            = 1'b1;
    bus.Run          = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.Ready), 64'd0);
    check("reset_product", bus.Product, 64'd0);
    chk_en = 1'b1;
    @(negedge clk);
    Reset = 1'b0;

    run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1, 1'b0, 1'b0);
`ifdef COMPMUL_SIGNED_EN
    run_op("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("mul_msb", 32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("mul_neg2x3", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0, 1'b0);
`else
    run_op("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, 1'b0);
    run_op("mul_msb", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0);
`endif
    run_op("mul_zero", 32'd0, 32'h1234_5678, 64'd0, 1'b1, 1'b0, 1'b0);
    run_op("latch_6x9", 32'd6, 32'd9, 64'd54, 1'b1, 1'b1, 1'b0);
    run_op("run_wiggle", 32'd1000, 32'd1001, 64'd1001000, 1'b1, 1'b0, 1'b1);

    // Abort in the middle of CALC.
    @(negedge clk);
    bus.Multiplicand = 32'h1234_5678;
    bus.Multiplier   = 32'h9ABC_DEF0;
    bus.Run          = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_ready", 64'(bus.Ready), 64'd0);
    check("abort_product", bus.Product, 64'd0);
    @(negedge clk);
    bus.Run = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    run_op("after_abort", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000,
           1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h7FFF_FFFF;
      run_op("random", ra, rb, ref_mul(ra, rb), 1'b0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
